// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle load/store unit. Takes one memory op at a time from
//            the datapath, drives a word-aligned handshaked bus access with
//            byte enables, extends load data and stalls the datapath until
//            the op completes, faults or times out.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;

  // Counter value seen during the last ACCESS cycle allowed before abort.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_legal;
  logic        w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_in_access;

  assign w_in_access = (r_state == c_access);

  // Decode legality and alignment of the incoming request.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    case (req_funct3)
      3'b000:  begin w_legal = 1'b1;     w_aligned = 1'b1; end
      3'b001:  begin w_legal = 1'b1;     w_aligned = ~req_addr[0]; end
      3'b010:  begin w_legal = 1'b1;     w_aligned = (req_addr[1:0] == 2'b00); end
      3'b100:  begin w_legal = ~req_we;  w_aligned = 1'b1; end
      3'b101:  begin w_legal = ~req_we;  w_aligned = ~req_addr[0]; end
      default: begin w_legal = 1'b0;     w_aligned = 1'b0; end
    endcase
  end

  // Byte enables and lane-replicated store data for the latched op.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
    if (!r_we) begin
      w_be = 4'b0000;
    end
  end

  // Select the addressed lane of the bus read data and extend it.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Control FSM: accept in IDLE, hold the bus in ACCESS, pulse in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_idle;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_cnt    <= 8'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 8'd0;
            r_rdata  <= 32'd0;
            if (w_legal && w_aligned) begin
              r_err   <= 1'b0;
              r_state <= c_access;
            end else begin
              r_err   <= 1'b1;
              r_state <= c_resp;
            end
          end
        end
        c_access: begin
          // An ack in the final counted cycle takes priority over timeout.
          if (mem_ack) begin
            r_rdata <= r_we ? 32'd0 : w_load;
            r_err   <= 1'b0;
            r_state <= c_resp;
          end else if (r_cnt == c_tmo_last) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
            r_state <= c_resp;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_resp: begin
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign req_ready = (r_state == c_idle);
  assign stall     = ((r_state == c_idle) && req_valid) || w_in_access;
  assign rsp_valid = (r_state == c_resp);
  assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;
  assign rsp_err   = rsp_valid & r_err;

  assign mem_req   = w_in_access;
  assign mem_we    = w_in_access & r_we;
  assign mem_addr  = w_in_access ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata = w_in_access ? w_wdata : 32'd0;
  assign mem_be    = w_in_access ? w_be : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit: directed cases plus
//            randomized ops compared against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit op_ok(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b0;
    return (a % op_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    be = 4'b0000;
    if (we) begin
      for (int i = 0; i < op_size(f3); i++) be[int'(a[1:0]) + i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] o;
    o = 32'd0;
    for (int n = 0; n < 4; n++) o[8*n +: 8] = wd[8*(n % op_size(f3)) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] mask;
    int sz;
    sz = op_size(f3);
    v  = rd >> (8 * int'(a[1:0]));
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Issue one op; waits = number of no-ack ACCESS cycles before ack.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    bit ok;
    bit acked;
    ok = op_ok(we, f3, a);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("stall_req", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    acked = 1'b0;
    if (ok) begin
      for (int c = 1; c <= T && !acked; c++) begin
        @(negedge clk);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(mem_be), 32'(exp_be(we, f3, a)));
        if (we) chk("mem_wdata", mem_wdata, exp_wdata(f3, wd));
        chk("stall_access", 32'(stall), 32'd1);
        chk("rsp_valid_access", 32'(rsp_valid), 32'd0);
        if (c - 1 == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
          acked     = 1'b1;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(!(ok && acked)));
    chk("rsp_rdata", rsp_rdata, (ok && acked && !we) ? exp_rdata(f3, a, rd) : 32'd0);
    chk("stall_resp", 32'(stall), 32'd0);
    chk("mem_req_resp", 32'(mem_req), 32'd0);
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);   // LB
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 3);   // LHU, ack in last cycle
    run_op(1'b1, 3'b000, 32'h201, 32'h1234_56AB, 32'h0, 1);   // SB
    run_op(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 0);   // SH
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);           // LW misaligned
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);           // illegal funct3
    run_op(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);           // store with load-only code
    run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 99);          // timeout
    run_op(1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFE_F00D, 2);   // normal LW after timeout

    // Reset during the second ACCESS cycle
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc_mem_req1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("rstacc_mem_req2", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstacc_mem_req", 32'(mem_req), 32'd0);
    chk("rstacc_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstacc_req_ready", 32'(req_ready), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_req_ready", 32'(req_ready), 32'd1);
    chk("stray_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;

    // Randomized ops
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : {a[1], 1'b0};
      run_op(we, f3, a, $urandom, $urandom, int'($urandom_range(0, T + 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle datapath's ALU/register-file outputs and a handshaked data memory. It accepts one memory operation at a time (effective address from the ALU result, store data from rs2), generates word-aligned bus accesses with byte enables, and sign- or zero-extends load data for writeback. It holds the datapath stalled until the operation completes, errors, or times out.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without mem_ack before abort (1..255, 8-bit counter)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  datapath requests a memory op
- req_ready  out  1  unit can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- stall  out  1  freeze PC/regfile while high
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_err  out  1  valid with rsp_valid: misaligned, illegal funct3, or timeout
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables (bit n = byte lane n)
- mem_ack  in  1  bus completion; mem_rdata valid same cycle
- mem_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr, wdata. If legal and aligned -> ACCESS, else -> RESP with err=1 (no bus activity).
- Legal: loads 000,001,010,100,101; stores 000,001,010. Everything else illegal.
- Aligned: H/HU need addr[0]=0; W needs addr[1:0]=00; B always aligned.
- ACCESS: mem_req=1, mem_we/addr/wdata/be stable throughout. On mem_ack: capture and extend data, -> RESP. Counter increments each ACCESS cycle without ack; upon reaching TIMEOUT_CYCLES, drop mem_req, -> RESP with err=1, rdata=0.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. No request is accepted in RESP.
- Byte enables: B -> 1<<addr[1:0]; H -> addr[1]?1100:0011; W -> 1111; all-zero on loads.
- Store wdata: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
- Load extract: byte lane addr[1:0] or halfword lane addr[1]; B/H sign-extend bit 7/15, BU/HU zero-extend, W passes through.
- stall = (IDLE && req_valid) || ACCESS. Low in RESP, so the datapath writes back rsp_rdata in that cycle.
- mem_ack while not in ACCESS is ignored.

## Timing
- Reset (synchronous): state=IDLE, counter=0, all outputs 0 except req_ready=1. Reset during ACCESS drops mem_req on the following edge; the aborted op produces no rsp_valid.
- Accept at cycle 0 -> mem_req from cycle 1 -> ack at cycle k (k>=1) -> rsp_valid at cycle k+1. Minimum latency is 2 cycles.
- Error path: accept at cycle 0 -> rsp_valid+rsp_err at cycle 1.
- Timeout: mem_req high for cycles 1..TIMEOUT_CYCLES; rsp_valid+err at cycle TIMEOUT_CYCLES+1. An ack arriving in the final counted cycle wins over timeout.
- Back-to-back: the next request is accepted no earlier than the IDLE cycle after RESP (one op per >=3 cycles).
- rsp_rdata/rsp_err are registered, valid only while rsp_valid; otherwise 0.

## Test plan
- LB addr 0x103, mem_rdata 0x80FF_1234, ack first cycle -> mem_addr 0x100, be 0000, rsp_rdata 0xFFFF_FF80 at cycle 2, err 0.
- LHU addr 0x102, mem_rdata 0x8001_0000, ack after 3 wait cycles -> rsp_rdata 0x0000_8001 at cycle 5; stall high cycles 0-4.
- SB addr 0x201, wdata 0x1234_56AB -> mem_we 1, be 0010, mem_wdata 0xABAB_ABAB; SH addr 0x202, wdata 0xBEEF -> be 1100, mem_wdata 0xBEEF_BEEF.
- LW addr 0x102 and funct3 011 -> no mem_req, rsp_valid+rsp_err at cycle 1, rsp_rdata 0.
- TIMEOUT_CYCLES=4, no ack -> mem_req cycles 1-4, err at cycle 5; then a new LW ack'd normally -> err 0, correct data.
- Reset asserted in the 2nd ACCESS cycle -> mem_req 0 next cycle, no rsp_valid, req_ready 1; a stray mem_ack afterwards has no effect.
